// File: rtl/song_player_if.sv
// rtl/song_player_if.sv - song ROM lookup bus between the player and its note table
interface song_player_if #(
    parameter int ADDR_W = 5,
    parameter int PER_W  = 18
);
    logic [ADDR_W-1:0] note_addr;
    logic [PER_W-1:0]  note_period;

    modport master (
        output note_addr,
        input  note_period
    );

    modport slave (
        input  note_addr,
        output note_period
    );
endinterface

// File: rtl/song_player.sv
// rtl/song_player.sv - beat sequencer over a song ROM driving a volume-scaled square wave
module song_player #(
    parameter int ADDR_W      = 5,
    parameter int SONG_LEN    = 32,
    parameter int PER_W       = 18,
    parameter int BEAT_CYCLES = 12_500_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         volume,
    input  logic               song_pause,
    song_player_if.master      rom,
    output logic               audio_out,
    output logic               beat_tick,
    output logic               song_wrap
);
    localparam int                BEAT_W    = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [PER_W-1:0]  PER_MIN   = PER_W'(2);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PER_W-1:0]  tone_q, tone_d;
    logic              load_q, load_d;
    logic              audio_q, audio_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              beat_done;
    logic [PER_W-1:0]  thr;

    always_comb begin
        case (volume)
            2'd0:    thr = '0;
            2'd1:    thr = period_q >> 3;
            2'd2:    thr = period_q >> 2;
            default: thr = period_q >> 1;
        endcase
    end

    // Pause outranks beat completion: a paused edge never advances anything.
    assign beat_done = !song_pause && (beat_cnt_q == BEAT_LAST);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        period_d   = period_q;
        tone_d     = tone_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        load_d     = beat_done;

        if (beat_done) begin
            beat_cnt_d = '0;
            tick_d     = 1'b1;
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end else if (!song_pause) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        // The load samples the ROM at the address set by the previous edge.
        if (load_q) begin
            period_d = rom.note_period;
            tone_d   = '0;
        end else if (!song_pause) begin
            if (period_q < PER_MIN || tone_q == period_q - 1'b1) begin
                tone_d = '0;
            end else begin
                tone_d = tone_q + 1'b1;
            end
        end

        audio_d = !song_pause && (period_q >= PER_MIN) && (tone_q < thr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            addr_q     <= '0;
            period_q   <= '0;
            tone_q     <= '0;
            load_q     <= 1'b1;
            audio_q    <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            period_q   <= period_d;
            tone_q     <= tone_d;
            load_q     <= load_d;
            audio_q    <= audio_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign rom.note_addr = addr_q;
    assign audio_out     = audio_q;
    assign beat_tick     = tick_q;
    assign song_wrap     = wrap_q;
endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - scoreboard bench for song_player against a behavioural playback model
module tb_song_player;
    localparam int ADDR_W = 2;
    localparam int LEN    = 4;
    localparam int BC     = 16;
    localparam int PER_W  = 8;

    typedef struct {
        int addr;
        int audio;
        int tick;
        int wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] volume = 2'd0;
    logic       song_pause = 1'b0;
    logic       audio_out, beat_tick, song_wrap;
    logic       last_audio;

    int rom [LEN] = '{8, 0, 16, 1};
    int duty_exp [4] = '{0, 1, 2, 4};

    song_player_if #(.ADDR_W(ADDR_W), .PER_W(PER_W)) rif ();
    assign rif.note_period = PER_W'(rom[rif.note_addr]);

    song_player #(
        .ADDR_W(ADDR_W), .SONG_LEN(LEN), .PER_W(PER_W), .BEAT_CYCLES(BC)
    ) dut (
        .clk(clk), .rst(rst), .volume(volume), .song_pause(song_pause),
        .rom(rif), .audio_out(audio_out), .beat_tick(beat_tick), .song_wrap(song_wrap)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb [$];

    // Model state: position in song, unpaused cycles into the beat,
    // the note being played and how many unpaused cycles it has sounded.
    int m_addr = 0, m_beat = 0, m_per = 0, m_run = 0, m_load = 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int duty_thr(input int v, input int p);
        return (v == 0) ? 0 : (p >> (4 - v));
    endfunction

    function automatic exp_t model_edge(input bit r, input bit p, input int v);
        exp_t e;
        int   old_addr;
        bit   adv;
        e = '{0, 0, 0, 0};
        if (!r) begin
            m_addr = 0; m_beat = 0; m_per = 0; m_run = 0; m_load = 1;
            return e;
        end
        if (!p && m_per >= 2)
            e.audio = ((m_run % m_per) < duty_thr(v, m_per)) ? 1 : 0;
        old_addr = m_addr;
        adv      = !p && (m_beat == BC - 1);
        if (adv) begin
            e.tick = 1;
            e.wrap = (m_addr == LEN - 1) ? 1 : 0;
            m_beat = 0;
            m_addr = (m_addr + 1) % LEN;
        end else if (!p) begin
            m_beat++;
        end
        if (m_load != 0) begin
            m_per = rom[old_addr];
            m_run = 0;
        end else if (!p) begin
            m_run++;
        end
        m_load = adv ? 1 : 0;
        e.addr = m_addr;
        return e;
    endfunction

    task automatic cycle(input bit r, input bit p, input int v);
        @(negedge clk);
        last_audio = audio_out;
        rst        = r;
        song_pause = p;
        volume     = 2'(v);
        sb.push_back(model_edge(r, p, v));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("note_addr", int'(rif.note_addr), e.addr);
                check("audio_out", int'(audio_out), e.audio);
                check("beat_tick", int'(beat_tick), e.tick);
                check("song_wrap", int'(song_wrap), e.wrap);
            end
        end
    end

    initial begin
        int highs, n, vol, p;
        bit got;

        // Reset, then the first load must capture note 0.
        for (int i = 0; i < 3; i++) cycle(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        cycle(1, 0, 3);
        @(posedge clk); #1;
        check("cur_period_first_load", int'(dut.period_q), 8);

        // Duty over one tone period of note 0 at each volume.
        for (int v = 0; v < 4; v++) begin
            cycle(0, 0, v);
            cycle(0, 0, v);
            highs = 0;
            for (int ed = 1; ed <= 10; ed++) begin
                cycle(1, 0, v);
                if (ed >= 3) highs += int'(last_audio);
            end
            check($sformatf("duty_vol%0d", v), highs, duty_exp[v]);
        end

        // Pause at beat_cnt=5 for 40 cycles; the beat must finish 11 cycles after release.
        cycle(0, 0, 3);
        for (int i = 0; i < 5; i++) cycle(1, 0, 3);
        for (int i = 0; i < 40; i++) cycle(1, 1, 3);
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            cycle(1, 0, 3);
            n++;
            @(posedge clk); #1;
            got = beat_tick;
        end
        check("pause_resume_ticks", n, 11);

        // Full song at loudest, then a reset while note 2 is sounding.
        cycle(0, 0, 3);
        for (int i = 0; i < 37; i++) cycle(1, 0, 3);
        cycle(0, 0, 3);
        for (int i = 0; i < 70; i++) cycle(1, 0, 3);

        // Randomised volume, pause and occasional reset.
        vol = 2;
        p   = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) vol = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) p = 1 - p;
            cycle(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, 1'(p), vol);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
